// File: rtl/ps2_multi_tx_pkg.sv
// Shared definitions for the PS/2 transmitter bank: frame state encoding.
package ps2_multi_tx_pkg;

    typedef logic [3:0] ps2_state_t;

    localparam ps2_state_t PS2_IDLE  = 4'd0;
    localparam ps2_state_t PS2_START = 4'd1;
    localparam ps2_state_t PS2_PAR   = 4'd9;
    localparam ps2_state_t PS2_STOP  = 4'd10;
    localparam ps2_state_t PS2_DONE  = 4'd11;

endpackage

// File: rtl/ps2_multi_tx_chan.sv
// One PS/2 device-side transmit channel: byte FIFO, host-inhibit synchroniser,
// 11-bit frame serialiser and sticky overflow flag.
module ps2_multi_tx_chan
    import ps2_multi_tx_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       tick,
    input  logic       clk_ps2,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    input  logic       ps2_clk_in,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overflow,
    output logic       busy
);

    localparam int DEPTH = 2 ** FIFO_BITS;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_BITS:0] wptr;
    logic [FIFO_BITS:0] rptr;
    logic [1:0]         clk_sync;
    logic               inh;
    ps2_state_t         state;
    logic [7:0]         shreg;
    logic               parity;
    logic               data_q;
    logic               overflow_q;
    logic               empty;
    logic               full;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[FIFO_BITS] != rptr[FIFO_BITS]) &&
                   (wptr[FIFO_BITS-1:0] == rptr[FIFO_BITS-1:0]);

    assign inh        = ~clk_sync[1];
    assign ps2_clk    = clk_ps2 | (state == PS2_IDLE);
    assign ps2_data   = data_q;
    assign fifo_empty = empty;
    assign fifo_full  = full;
    assign overflow   = overflow_q;
    assign busy       = (state != PS2_IDLE);

    // Bring the asynchronous host clock-line sense into clk_sys; idles released (high).
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
        end
    end

    // FIFO storage carries no reset; only the pointers define its contents.
    always_ff @(posedge clk_sys) begin
        if (wr_en && !full) begin
            mem[wptr[FIFO_BITS-1:0]] <= wr_data;
        end
    end

    // Write pointer and sticky overflow; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en && !full) begin
                wptr <= wptr + 1'b1;
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Frame serialiser: host inhibit aborts at once, otherwise advance one bit per tick.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state  <= PS2_IDLE;
            data_q <= 1'b1;
            shreg  <= '0;
            parity <= 1'b1;
            rptr   <= '0;
        end else if (inh && (state != PS2_IDLE)) begin
            state  <= PS2_IDLE;
            data_q <= 1'b1;
        end else if (tick) begin
            case (state)
                PS2_IDLE: begin
                    if (!empty && !inh) begin
                        state  <= PS2_START;
                        data_q <= 1'b0;
                        shreg  <= mem[rptr[FIFO_BITS-1:0]];
                        parity <= 1'b1;
                    end
                end
                PS2_PAR: begin
                    data_q <= parity;
                    state  <= PS2_STOP;
                end
                PS2_STOP: begin
                    data_q <= 1'b1;
                    state  <= PS2_DONE;
                end
                PS2_DONE: begin
                    rptr  <= rptr + 1'b1;
                    state <= PS2_IDLE;
                end
                default: begin
                    data_q <= shreg[0];
                    shreg  <= {1'b0, shreg[7:1]};
                    parity <= parity ^ shreg[0];
                    state  <= state + 4'd1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ps2_multi_tx.sv
// Bank of PS/2 device-side transmitters sharing one PS/2 bit-clock divider.
module ps2_multi_tx
    import ps2_multi_tx_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [2:0]          wr_ch,
    input  logic [7:0]          wr_data,
    input  logic [CHANNELS-1:0] clr_ovf,
    input  logic [CHANNELS-1:0] ps2_clk_in,
    output logic [CHANNELS-1:0] ps2_clk,
    output logic [CHANNELS-1:0] ps2_data,
    output logic [CHANNELS-1:0] fifo_empty,
    output logic [CHANNELS-1:0] fifo_full,
    output logic [CHANNELS-1:0] overflow,
    output logic [CHANNELS-1:0] busy
);

    localparam int DIV_W = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             clk_ps2;
    logic             tick;

    // Shared divider: clk_ps2 toggles every PS2DIV cycles, tick marks each rising half.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            clk_ps2 <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (div_cnt == DIV_W'(PS2DIV - 1)) begin
                div_cnt <= '0;
                clk_ps2 <= ~clk_ps2;
                tick    <= ~clk_ps2;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Out-of-range channel indices match no instance, so those writes vanish.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        ps2_multi_tx_chan #(
            .FIFO_BITS(FIFO_BITS)
        ) u_chan (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .tick      (tick),
            .clk_ps2   (clk_ps2),
            .wr_en     (wr_en && (wr_ch == 3'(i))),
            .wr_data   (wr_data),
            .clr_ovf   (clr_ovf[i]),
            .ps2_clk_in(ps2_clk_in[i]),
            .ps2_clk   (ps2_clk[i]),
            .ps2_data  (ps2_data[i]),
            .fifo_empty(fifo_empty[i]),
            .fifo_full (fifo_full[i]),
            .overflow  (overflow[i]),
            .busy      (busy[i])
        );
    end

endmodule

// File: tb/tb_ps2_multi_tx.sv
// Directed bench for ps2_multi_tx: frame contents, FIFO status, inhibit retransmit, reset abort.
module tb_ps2_multi_tx;

    localparam int CHANNELS  = 2;
    localparam int FIFO_BITS = 3;
    localparam int PS2DIV    = 4;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = '0;
    logic [7:0] wr_data = '0;
    logic [1:0] clr_ovf = '0;
    logic [1:0] ps2_clk_in = 2'b11;
    logic [1:0] ps2_clk;
    logic [1:0] ps2_data;
    logic [1:0] fifo_empty;
    logic [1:0] fifo_full;
    logic [1:0] overflow;
    logic [1:0] busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          ch;
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs [8];

    always #5 clk_sys = ~clk_sys;

    ps2_multi_tx #(
        .CHANNELS (CHANNELS),
        .FIFO_BITS(FIFO_BITS),
        .PS2DIV   (PS2DIV)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .clr_ovf   (clr_ovf),
        .ps2_clk_in(ps2_clk_in),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .busy      (busy)
    );

    // Frame as sent, bit 0 first: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic apply_stimulus(input int ch, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_ch   = 3'(ch);
        wr_data = data;
        @(posedge clk_sys);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        reset = 1'b0;
    endtask

    // Host-style capture: sample data on each falling ps2_clk of the selected channels.
    task automatic capture(input logic [1:0] mask, input int nbits,
                           output logic [10:0] bits0, output logic [10:0] bits1,
                           output int first0, output int first1, output logic ok);
        logic [1:0] prev;
        int n0;
        int n1;
        int cyc;
        n0 = 0;
        n1 = 0;
        cyc = 0;
        bits0 = '0;
        bits1 = '0;
        first0 = -1;
        first1 = -1;
        prev = ps2_clk;
        while (((mask[0] && n0 < nbits) || (mask[1] && n1 < nbits)) && cyc < 300) begin
            @(posedge clk_sys);
            #1;
            cyc++;
            if (mask[0] && prev[0] && !ps2_clk[0] && n0 < nbits) begin
                bits0[n0] = ps2_data[0];
                if (n0 == 0) first0 = cyc;
                n0++;
            end
            if (mask[1] && prev[1] && !ps2_clk[1] && n1 < nbits) begin
                bits1[n1] = ps2_data[1];
                if (n1 == 0) first1 = cyc;
                n1++;
            end
            prev = ps2_clk;
        end
        ok = (!mask[0] || n0 == nbits) && (!mask[1] || n1 == nbits);
    endtask

    task automatic wait_idle(input int ch, output logic ok);
        int cyc;
        cyc = 0;
        while (busy[ch] && cyc < 40) begin
            step(1);
            cyc++;
        end
        ok = !busy[ch];
    endtask

    initial begin
        logic [10:0] b0;
        logic [10:0] b1;
        int          f0;
        int          f1;
        logic        ok;
        int          lows;

        vecs[0] = '{0, 8'h1C, 11'b10000111000};
        vecs[1] = '{0, 8'hFF, 11'b11111111110};
        vecs[2] = '{1, 8'h00, 11'b11000000000};
        vecs[3] = '{1, 8'h01, 11'b10000000010};
        vecs[4] = '{0, 8'h80, 11'b10100000000};
        vecs[5] = '{1, 8'hA5, 11'b11101001010};
        vecs[6] = '{0, 8'hAA, 11'b11101010100};
        vecs[7] = '{1, 8'h55, 11'b11010101010};

        do_reset();
        check_output("rst_ps2_clk", 32'(ps2_clk), 32'h3);
        check_output("rst_ps2_data", 32'(ps2_data), 32'h3);
        check_output("rst_empty", 32'(fifo_empty), 32'h3);
        check_output("rst_full", 32'(fifo_full), 32'h0);
        check_output("rst_overflow", 32'(overflow), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);

        // Writes to nonexistent channels must leave everything untouched.
        apply_stimulus(2, 8'h77);
        apply_stimulus(7, 8'h77);
        step(1);
        check_output("badch_empty", 32'(fifo_empty), 32'h3);
        check_output("badch_overflow", 32'(overflow), 32'h0);
        step(20);
        check_output("badch_busy", 32'(busy), 32'h0);

        // Table-driven single frames.
        for (int v = 0; v < 8; v++) begin
            apply_stimulus(vecs[v].ch, vecs[v].data);
            capture(vecs[v].ch == 0 ? 2'b01 : 2'b10, 11, b0, b1, f0, f1, ok);
            check_output($sformatf("vec%0d_timeout", v), 32'(ok), 32'h1);
            check_output($sformatf("vec%0d_frame", v), 32'(vecs[v].ch == 0 ? b0 : b1), 32'(vecs[v].frame));
            wait_idle(vecs[v].ch, ok);
            check_output($sformatf("vec%0d_idle", v), 32'(ok), 32'h1);
            check_output($sformatf("vec%0d_empty", v), 32'(fifo_empty[vecs[v].ch]), 32'h1);
            lows = 0;
            for (int c = 0; c < 16; c++) begin
                step(1);
                if (!ps2_clk[vecs[v].ch]) lows++;
            end
            check_output($sformatf("vec%0d_clk_held", v), 32'(lows), 32'h0);
        end

        // Fill ch1 while inhibited, then overflow and clear.
        ps2_clk_in[1] = 1'b0;
        step(3);
        for (int k = 0; k < 8; k++) apply_stimulus(1, 8'(8'h10 + k));
        check_output("fill_full", 32'(fifo_full[1]), 32'h1);
        check_output("fill_ovf", 32'(overflow[1]), 32'h0);
        check_output("fill_busy", 32'(busy[1]), 32'h0);
        apply_stimulus(1, 8'h18);
        check_output("ovf_set", 32'(overflow[1]), 32'h1);
        check_output("ovf_other_ch", 32'(overflow[0]), 32'h0);
        clr_ovf[1] = 1'b1;
        step(1);
        clr_ovf[1] = 1'b0;
        check_output("ovf_clear", 32'(overflow[1]), 32'h0);
        clr_ovf[1] = 1'b1;
        apply_stimulus(1, 8'h99);
        clr_ovf[1] = 1'b0;
        check_output("ovf_clr_collide", 32'(overflow[1]), 32'h1);
        clr_ovf[1] = 1'b1;
        step(1);
        clr_ovf[1] = 1'b0;
        check_output("ovf_clear2", 32'(overflow[1]), 32'h0);
        ps2_clk_in[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            capture(2'b10, 11, b0, b1, f0, f1, ok);
            check_output($sformatf("drain%0d_timeout", k), 32'(ok), 32'h1);
            check_output($sformatf("drain%0d_frame", k), 32'(b1), 32'(frame_of(8'(8'h10 + k))));
        end
        wait_idle(1, ok);
        check_output("drain_idle", 32'(ok), 32'h1);
        check_output("drain_empty", 32'(fifo_empty[1]), 32'h1);

        // Inhibit during data bit 4, then full retransmit.
        apply_stimulus(0, 8'hA5);
        capture(2'b01, 5, b0, b1, f0, f1, ok);
        check_output("inh_pre_timeout", 32'(ok), 32'h1);
        step(6);
        ps2_clk_in[0] = 1'b0;
        step(3);
        check_output("inh_clk", 32'(ps2_clk[0]), 32'h1);
        check_output("inh_data", 32'(ps2_data[0]), 32'h1);
        check_output("inh_busy", 32'(busy[0]), 32'h0);
        check_output("inh_not_popped", 32'(fifo_empty[0]), 32'h0);
        step(20);
        check_output("inh_hold_busy", 32'(busy[0]), 32'h0);
        ps2_clk_in[0] = 1'b1;
        capture(2'b01, 11, b0, b1, f0, f1, ok);
        check_output("retx_timeout", 32'(ok), 32'h1);
        check_output("retx_frame", 32'(b0), 32'(11'b11101001010));
        wait_idle(0, ok);
        check_output("retx_idle", 32'(ok), 32'h1);
        check_output("retx_empty", 32'(fifo_empty[0]), 32'h1);

        // Concurrent frames from a fresh reset start on the same tick.
        do_reset();
        apply_stimulus(0, 8'hAA);
        apply_stimulus(1, 8'h55);
        capture(2'b11, 11, b0, b1, f0, f1, ok);
        check_output("conc_timeout", 32'(ok), 32'h1);
        check_output("conc_frame0", 32'(b0), 32'(11'b11101010100));
        check_output("conc_frame1", 32'(b1), 32'(11'b11010101010));
        check_output("conc_start0", 32'(f0), 32'd6);
        check_output("conc_start1", 32'(f1), 32'd6);
        wait_idle(0, ok);
        wait_idle(1, ok);
        check_output("conc_idle", 32'(busy), 32'h0);

        // Reset in the middle of bit 5 with bytes still queued.
        apply_stimulus(0, 8'h11);
        apply_stimulus(0, 8'h22);
        apply_stimulus(0, 8'h33);
        capture(2'b01, 6, b0, b1, f0, f1, ok);
        check_output("rstmid_timeout", 32'(ok), 32'h1);
        step(6);
        #3;
        reset = 1'b1;
        #1;
        check_output("rstmid_ps2_clk", 32'(ps2_clk), 32'h3);
        check_output("rstmid_ps2_data", 32'(ps2_data), 32'h3);
        check_output("rstmid_empty", 32'(fifo_empty), 32'h3);
        check_output("rstmid_full", 32'(fifo_full), 32'h0);
        check_output("rstmid_busy", 32'(busy), 32'h0);
        @(posedge clk_sys);
        #1;
        reset = 1'b0;
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            step(1);
            if (!ps2_clk[0] || !fifo_empty[0]) lows++;
        end
        check_output("rstmid_no_frames", 32'(lows), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
